anita_multi_phi_l2_trigger: RTL and testbench
=============================================

Name: anita_multi_phi_l2_trigger

Overview:
- Parametrised, next-generation L2 trigger. Takes single-cycle L1 ring flags (top/mid/bot), already synchronised to clk_i, for NPHI phi sectors.
- Per sector: forms ring-pair coincidences with programmable windows, a run-time mode and a mask, and produces a fixed-width L2 trigger pulse followed by a holdoff.
- Per-sector saturating L2 event counters are snapshotted on request.
- Sits between the per-antenna L1 stage and the TURF trigger output / housekeeping scaler readout.

Parameters:
- NPHI, 2, number of phi sectors.
- MT_WIN, 2, mid->top window in clk_i cycles (1..15).
- BT_WIN, 3, bot->top window in cycles (1..15).
- MB_WIN, 1, mid/bot mutual window in cycles (1..15).
- L2_WIDTH, 3, trig_o pulse width in cycles (1..15).
- HOLDOFF, 2, dead cycles after the pulse (0..15).
- CNT_W, 16, L2 scaler counter width.

Ports:
- clk_i  in  1  trigger clock (250 MHz)
- rst_i  in  1  synchronous, active-high reset
- top_i  in  NPHI  top-ring L1 flag, bit p = sector p
- mid_i  in  NPHI  middle-ring L1 flag
- bot_i  in  NPHI  bottom-ring L1 flag
- mask_i  in  NPHI  1 = sector p disabled
- mode_i  in  2  0=any 2-of-3, 1=top-required, 2=3-of-3, 3=any single ring
- scaler_latch_i  in  1  snapshot-and-clear request
- trig_o  out  NPHI  L2 trigger pulse per sector
- trig_any_o  out  1  registered OR of the next-cycle trig_o values
- scaler_o  out  NPHI*CNT_W  latched counts; sector p at bits [p*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_i high at a clock edge): all internal registers, window counters, state, trig_o, trig_any_o and scaler_o go to 0. Reset wins over every other event, including mid-pulse and mid-holdoff.
- Stage 1: top_i/mid_i/bot_i are registered (top_q, mid_q, bot_q). top_q is registered again to top_d. mid_q/bot_q are registered to mid_d/bot_d for mode 3.
- Windows: each sector has 4-bit down-counters mt_cnt, bt_cnt, mbm_cnt, mbb_cnt.
  - When mid_q=1 and the counter is 0, load mt_cnt=MT_WIN and mbm_cnt=MB_WIN. bot_q loads bt_cnt=BT_WIN and mbb_cnt=MB_WIN the same way.
  - Windows are non-retriggerable: a new flag while a counter is nonzero is ignored.
  - A nonzero counter decrements by 1 per cycle. A window is open while its counter is nonzero.
- Alignment: input at edge k gives top_d valid after edge k+2, and windows open after edge k+2. Consequences:
  - Top after mid by 0..MT_WIN-1 cycles coincides; top before mid does not.
  - Mid/bot coincide if within MB_WIN-1 cycles of each other.
- Coincidence terms:
  - TM = top_d & (mt_cnt!=0)
  - TB = top_d & (bt_cnt!=0)
  - MB = (mbm_cnt!=0) & (mbb_cnt!=0)
- Coincidence condition by mode:
  - mode 0: TM | TB | MB.
  - mode 1: TM | TB.
  - mode 2: TM & TB.
  - mode 3: top_d | mid_d | bot_d.
- mode_i is sampled every cycle; a change applies from the next evaluation.
- Per-sector FSM:
  - IDLE: if condition and !mask_i[p], go to FIRE and load width counter = L2_WIDTH.
  - FIRE: trig_o[p]=1. On the last cycle go to HOLD (load HOLDOFF), or to IDLE if HOLDOFF=0.
  - HOLD: trig_o[p]=0. Go to IDLE when the counter expires.
  - A condition arising outside IDLE is ignored.
- Latency: coincident input at edge k gives trig_o high after edge k+3, for exactly L2_WIDTH cycles. Minimum retrigger spacing is L2_WIDTH+HOLDOFF cycles.
- Window consumption: the cycle a sector enters FIRE, all four of its window counters clear to 0.
- Mask: while mask_i[p]=1, sector p's counters are held at 0 and it stays in IDLE. Asserting the mask mid-FIRE/HOLD does not truncate the pulse or holdoff.
- Scalers:
  - cnt[p] increments by 1 on each IDLE->FIRE entry and saturates at 2^CNT_W-1.
  - When scaler_latch_i=1: scaler_o[p] <= cnt[p] and cnt[p] clears. If an entry happens in the same cycle, cnt[p] becomes 1 and scaler_o takes the pre-increment value, so no event is lost.
  - scaler_o holds between latches.

Decomposition:
- Package anita_trig_pkg holds:
  - mode constants MODE_ANY2, MODE_TOPREQ, MODE_ALL3, MODE_SINGLE.
  - FSM state encoding IDLE/FIRE/HOLD (2-bit).
  - window counter width WIN_W=4.
- Sub-module anita_l2_sector: one phi sector, containing the windows, coincidence, FSM and counter. It is instantiated NPHI times in a generate loop.
- Top level holds only the input registers, trig_any_o and the scaler_o concatenation.

Test Plan:
- Defaults, mode 0: mid_i[0] pulse at edge 10, top_i[0] pulse at edge 11 -> trig_o[0] high after edge 14 for 3 cycles, then HOLD; scaler after latch = 1. Top at edge 12 (outside MT_WIN=2) -> no trigger.
- Mode 1: bot_i[1] at edge 5 and mid_i[1] at edge 5 -> no trigger. Same stimulus in mode 0 -> trig_o[1] high after edge 8.
- Mode 2: mid and bot at edge 20, top at edge 21 -> trigger. Only mid+top -> none.
- Mode 3: top_i[0] pulse every cycle for 20 cycles -> trig_o[0] pulses of 3 high / 2 low repeating (4 pulses), counter = 4.
- mask_i[1]=1 with valid coincidences -> trig_o[1] stays 0 and cnt stays 0. Sector 0 triggers unaffected.
- Saturation and latch: CNT_W=4, 17 triggers -> scaler_o = 15. Latch in the same cycle as a trigger -> scaler_o = old value, next latch = 1. rst_i asserted mid-FIRE -> trig_o = 0 next cycle and all scalers = 0.

Source files
------------

// File: rtl/anita_trig_pkg.sv
// Shared types and constants for the multi-phi L2 trigger: mode codes, sector FSM states
// and the window down-counter step used by every coincidence window.
package anita_trig_pkg;

  localparam int WIN_W = 4;

  localparam logic [1:0] MODE_ANY2   = 2'd0;
  localparam logic [1:0] MODE_TOPREQ = 2'd1;
  localparam logic [1:0] MODE_ALL3   = 2'd2;
  localparam logic [1:0] MODE_SINGLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } l2_state_e;

  // Non-retriggerable window: an open window ignores new flags until it runs out.
  function automatic logic [WIN_W-1:0] win_step(input logic [WIN_W-1:0] cnt,
                                                input logic             flag,
                                                input logic [WIN_W-1:0] len);
    if (cnt != '0) return cnt - WIN_W'(1);
    else if (flag) return len;
    else return '0;
  endfunction

endpackage

// File: rtl/anita_l2_sector.sv
// One phi sector: ring-pair windows, mode-selected coincidence, pulse/holdoff FSM, event scaler.
// Trigger one cycle after the coincidence is seen; no backpressure, conditions outside IDLE are dropped.
module anita_l2_sector
  import anita_trig_pkg::*;
#(
  parameter int MT_WIN   = 2,
  parameter int BT_WIN   = 3,
  parameter int MB_WIN   = 1,
  parameter int L2_WIDTH = 3,
  parameter int HOLDOFF  = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             top_d,
  input  logic             mid_q,
  input  logic             bot_q,
  input  logic             mid_d,
  input  logic             bot_d,
  input  logic             mask,
  input  logic [1:0]       mode,
  input  logic             scaler_latch,
  output logic             trig_nxt,
  output logic             trig,
  output logic [CNT_W-1:0] scaler
);

  localparam logic [WIN_W-1:0] MT_LEN   = WIN_W'(MT_WIN);
  localparam logic [WIN_W-1:0] BT_LEN   = WIN_W'(BT_WIN);
  localparam logic [WIN_W-1:0] MB_LEN   = WIN_W'(MB_WIN);
  localparam logic [WIN_W-1:0] W_LEN    = WIN_W'(L2_WIDTH);
  localparam logic [WIN_W-1:0] HOLD_LEN = WIN_W'(HOLDOFF);
  localparam logic [WIN_W-1:0] TMR_ONE  = WIN_W'(1);

  logic [WIN_W-1:0] mt_cnt;
  logic [WIN_W-1:0] bt_cnt;
  logic [WIN_W-1:0] mbm_cnt;
  logic [WIN_W-1:0] mbb_cnt;

  l2_state_e        state_q;
  l2_state_e        state_nxt;
  logic [WIN_W-1:0] tmr_q;
  logic [WIN_W-1:0] tmr_nxt;
  logic             cond;
  logic             rdy;
  logic             enter;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || mask || enter) begin
      mt_cnt  <= '0;
      bt_cnt  <= '0;
      mbm_cnt <= '0;
      mbb_cnt <= '0;
    end else begin
      mt_cnt  <= win_step(mt_cnt, mid_q, MT_LEN);
      mbm_cnt <= win_step(mbm_cnt, mid_q, MB_LEN);
      bt_cnt  <= win_step(bt_cnt, bot_q, BT_LEN);
      mbb_cnt <= win_step(mbb_cnt, bot_q, MB_LEN);
    end
  end

  always_comb begin
    logic tm;
    logic tb;
    logic mb;
    tm = top_d && (mt_cnt != '0);
    tb = top_d && (bt_cnt != '0);
    mb = (mbm_cnt != '0) && (mbb_cnt != '0);
    cond = 1'b0;
    case (mode)
      MODE_ANY2:   cond = tm || tb || mb;
      MODE_TOPREQ: cond = tm || tb;
      MODE_ALL3:   cond = tm && tb;
      MODE_SINGLE: cond = top_d || mid_d || bot_d;
      default:     cond = 1'b0;
    endcase
  end

  // rdy marks the edge at which the sector is back in IDLE; the expiring HOLD (or FIRE with
  // no holdoff) cycle counts as that point so retrigger spacing is exactly L2_WIDTH+HOLDOFF.
  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    rdy       = 1'b0;
    enter     = 1'b0;
    case (state_q)
      IDLE: rdy = 1'b1;
      FIRE: begin
        if (tmr_q <= TMR_ONE) begin
          if (HOLDOFF == 0) begin
            state_nxt = IDLE;
            tmr_nxt   = '0;
            rdy       = 1'b1;
          end else begin
            state_nxt = HOLD;
            tmr_nxt   = HOLD_LEN;
          end
        end else begin
          tmr_nxt = tmr_q - TMR_ONE;
        end
      end
      HOLD: begin
        if (tmr_q <= TMR_ONE) begin
          state_nxt = IDLE;
          tmr_nxt   = '0;
          rdy       = 1'b1;
        end else begin
          tmr_nxt = tmr_q - TMR_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        tmr_nxt   = '0;
      end
    endcase
    if (rdy && cond && !mask) begin
      state_nxt = FIRE;
      tmr_nxt   = W_LEN;
      enter     = 1'b1;
    end
  end

  assign trig_nxt = (state_nxt == FIRE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      trig    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      tmr_q   <= tmr_nxt;
      trig    <= trig_nxt;
    end
  end

  // A latch coinciding with an entry hands out the old count and keeps the new event.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      scaler <= '0;
    end else if (scaler_latch) begin
      scaler <= cnt_q;
      cnt_q  <= enter ? CNT_W'(1) : '0;
    end else if (enter && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/anita_multi_phi_l2_trigger.sv
// L2 trigger top: registers the L1 ring flags, runs NPHI sector engines, ORs their triggers.
// Input to trig_o is three cycles; flags are single-cycle pulses with no backpressure.
module anita_multi_phi_l2_trigger
  import anita_trig_pkg::*;
#(
  parameter int NPHI     = 2,
  parameter int MT_WIN   = 2,
  parameter int BT_WIN   = 3,
  parameter int MB_WIN   = 1,
  parameter int L2_WIDTH = 3,
  parameter int HOLDOFF  = 2,
  parameter int CNT_W    = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NPHI-1:0]       top_i,
  input  logic [NPHI-1:0]       mid_i,
  input  logic [NPHI-1:0]       bot_i,
  input  logic [NPHI-1:0]       mask_i,
  input  logic [1:0]            mode_i,
  input  logic                  scaler_latch_i,
  output logic [NPHI-1:0]       trig_o,
  output logic                  trig_any_o,
  output logic [NPHI*CNT_W-1:0] scaler_o
);

  logic [NPHI-1:0] top_q;
  logic [NPHI-1:0] mid_q;
  logic [NPHI-1:0] bot_q;
  logic [NPHI-1:0] top_d;
  logic [NPHI-1:0] mid_d;
  logic [NPHI-1:0] bot_d;
  logic [NPHI-1:0] trig_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_q      <= '0;
      mid_q      <= '0;
      bot_q      <= '0;
      top_d      <= '0;
      mid_d      <= '0;
      bot_d      <= '0;
      trig_any_o <= 1'b0;
    end else begin
      top_q      <= top_i;
      mid_q      <= mid_i;
      bot_q      <= bot_i;
      top_d      <= top_q;
      mid_d      <= mid_q;
      bot_d      <= bot_q;
      trig_any_o <= |trig_nxt;
    end
  end

  for (genvar p = 0; p < NPHI; p++) begin : g_sector
    anita_l2_sector #(
      .MT_WIN   (MT_WIN),
      .BT_WIN   (BT_WIN),
      .MB_WIN   (MB_WIN),
      .L2_WIDTH (L2_WIDTH),
      .HOLDOFF  (HOLDOFF),
      .CNT_W    (CNT_W)
    ) u_sector (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .top_d        (top_d[p]),
      .mid_q        (mid_q[p]),
      .bot_q        (bot_q[p]),
      .mid_d        (mid_d[p]),
      .bot_d        (bot_d[p]),
      .mask         (mask_i[p]),
      .mode         (mode_i),
      .scaler_latch (scaler_latch_i),
      .trig_nxt     (trig_nxt[p]),
      .trig         (trig_o[p]),
      .scaler       (scaler_o[p*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_anita_multi_phi_l2_trigger.sv
// Directed bench for the multi-phi L2 trigger: windows, modes, mask, pulse shape, scalers, reset.
module tb_anita_multi_phi_l2_trigger;

  localparam int NPHI  = 2;
  localparam int CNT_W = 4;

  logic                  clk_i;
  logic                  rst_i;
  logic [NPHI-1:0]       top_i;
  logic [NPHI-1:0]       mid_i;
  logic [NPHI-1:0]       bot_i;
  logic [NPHI-1:0]       mask_i;
  logic [1:0]            mode_i;
  logic                  scaler_latch_i;
  logic [NPHI-1:0]       trig_o;
  logic                  trig_any_o;
  logic [NPHI*CNT_W-1:0] scaler_o;

  int n_chk;
  int n_fail;

  logic [31:0] tr0;
  logic [31:0] tr1;
  logic [31:0] tra;

  anita_multi_phi_l2_trigger #(
    .NPHI     (NPHI),
    .MT_WIN   (2),
    .BT_WIN   (3),
    .MB_WIN   (1),
    .L2_WIDTH (3),
    .HOLDOFF  (2),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .top_i          (top_i),
    .mid_i          (mid_i),
    .bot_i          (bot_i),
    .mask_i         (mask_i),
    .mode_i         (mode_i),
    .scaler_latch_i (scaler_latch_i),
    .trig_o         (trig_o),
    .trig_any_o     (trig_any_o),
    .scaler_o       (scaler_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Leaves the bench just after a rising edge; anything driven now is seen at the next edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input logic [1:0] t, input logic [1:0] m, input logic [1:0] b);
    top_i = t;
    mid_i = m;
    bot_i = b;
    step();
    top_i = '0;
    mid_i = '0;
    bot_i = '0;
  endtask

  task automatic latch();
    scaler_latch_i = 1'b1;
    step();
    scaler_latch_i = 1'b0;
  endtask

  task automatic capture(input int n, output logic [31:0] t0, output logic [31:0] t1,
                         output logic [31:0] ta);
    t0 = '0;
    t1 = '0;
    ta = '0;
    for (int i = 0; i < n; i++) begin
      step();
      t0[i] = trig_o[0];
      t1[i] = trig_o[1];
      ta[i] = trig_any_o;
    end
  endtask

  initial begin
    n_chk          = 0;
    n_fail         = 0;
    rst_i          = 1'b1;
    top_i          = '0;
    mid_i          = '0;
    bot_i          = '0;
    mask_i         = '0;
    mode_i         = 2'd0;
    scaler_latch_i = 1'b0;

    repeat (3) step();
    check("rst_trig", 32'(trig_o), 32'h0);
    check("rst_any", 32'(trig_any_o), 32'h0);
    check("rst_scaler", 32'(scaler_o), 32'h0);
    rst_i = 1'b0;
    repeat (2) step();

    // mode 0: mid then top one cycle later -> pulse 3 cycles after the top edge
    pulse(2'b00, 2'b01, 2'b00);
    pulse(2'b01, 2'b00, 2'b00);
    capture(8, tr0, tr1, tra);
    check("m0_tm_s0", tr0, 32'h0000000E);
    check("m0_tm_s1", tr1, 32'h0);
    check("m0_tm_any", tra, 32'h0000000E);
    latch();
    check("m0_scaler", 32'(scaler_o), 32'h01);

    // top two cycles after mid falls outside MT_WIN
    pulse(2'b00, 2'b01, 2'b00);
    step();
    pulse(2'b01, 2'b00, 2'b00);
    capture(8, tr0, tr1, tra);
    check("m0_late_top", tr0, 32'h0);

    // mid+bot: rejected in mode 1, accepted in mode 0
    mode_i = 2'd1;
    pulse(2'b00, 2'b10, 2'b10);
    capture(8, tr0, tr1, tra);
    check("m1_mb_s1", tr1, 32'h0);
    mode_i = 2'd0;
    pulse(2'b00, 2'b10, 2'b10);
    capture(8, tr0, tr1, tra);
    check("m0_mb_s1", tr1, 32'h0000000E);
    check("m0_mb_s0", tr0, 32'h0);

    // mode 2 needs both top pairs
    mode_i = 2'd2;
    pulse(2'b00, 2'b01, 2'b01);
    pulse(2'b01, 2'b00, 2'b00);
    capture(8, tr0, tr1, tra);
    check("m2_all3", tr0, 32'h0000000E);
    pulse(2'b00, 2'b01, 2'b00);
    pulse(2'b01, 2'b00, 2'b00);
    capture(8, tr0, tr1, tra);
    check("m2_mt_only", tr0, 32'h0);
    latch();
    check("scaler_b", 32'(scaler_o), 32'h11);

    // mode 3: continuous top for 20 cycles -> 3 high / 2 low, four pulses
    mode_i = 2'd3;
    top_i  = 2'b01;
    tr0    = '0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 19) top_i = '0;
      tr0[i] = trig_o[0];
    end
    check("m3_train", tr0, 32'h000E739C);
    pulse(2'b00, 2'b00, 2'b10);
    capture(8, tr0, tr1, tra);
    check("m3_bot_s1", tr1, 32'h0000000E);
    latch();
    check("m3_scaler", 32'(scaler_o), 32'h14);

    // mask sector 1: it never fires, sector 0 unaffected
    mode_i = 2'd0;
    mask_i = 2'b10;
    pulse(2'b00, 2'b11, 2'b00);
    pulse(2'b11, 2'b00, 2'b00);
    capture(8, tr0, tr1, tra);
    check("mask_s0", tr0, 32'h0000000E);
    check("mask_s1", tr1, 32'h0);
    check("mask_any", tra, 32'h0000000E);
    latch();
    check("mask_scaler", 32'(scaler_o), 32'h01);

    // mask raised mid-pulse does not cut the pulse short
    mask_i = 2'b00;
    pulse(2'b00, 2'b10, 2'b00);
    pulse(2'b10, 2'b00, 2'b00);
    repeat (2) step();
    check("mask_mid_pre", 32'(trig_o), 32'h2);
    mask_i = 2'b10;
    capture(6, tr0, tr1, tra);
    check("mask_mid_s1", tr1, 32'h3);
    mask_i = 2'b00;
    latch();
    check("mask_mid_scaler", 32'(scaler_o), 32'h10);

    // saturation: 17 events in a 4-bit scaler
    mode_i = 2'd3;
    for (int n = 0; n < 17; n++) begin
      pulse(2'b01, 2'b00, 2'b00);
      repeat (7) step();
    end
    latch();
    check("sat_scaler", 32'(scaler_o), 32'h0F);

    // latch on the same edge as an entry: old count out, new event kept
    for (int n = 0; n < 2; n++) begin
      pulse(2'b01, 2'b00, 2'b00);
      repeat (7) step();
    end
    pulse(2'b01, 2'b00, 2'b00);
    step();
    latch();
    check("latch_same_trig", 32'(trig_o), 32'h1);
    check("latch_same_old", 32'(scaler_o), 32'h02);
    repeat (7) step();
    latch();
    check("latch_same_next", 32'(scaler_o), 32'h01);

    // reset mid-FIRE
    pulse(2'b11, 2'b00, 2'b00);
    repeat (2) step();
    check("rst_pre_trig", 32'(trig_o), 32'h3);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    check("rst_mid_trig", 32'(trig_o), 32'h0);
    check("rst_mid_any", 32'(trig_any_o), 32'h0);
    check("rst_mid_scaler", 32'(scaler_o), 32'h0);
    capture(6, tr0, tr1, tra);
    check("rst_after_any", tra, 32'h0);
    latch();
    check("rst_cnt_clear", 32'(scaler_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
